fetch_stage: RTL and testbench

Instruction-fetch stage wrapping the program counter register. It computes `next_pc` and `pc_en` for the PC register and drives the instruction-memory address. It captures the fetched word into the IF/ID pipeline register and applies decode-stage stalls and execute-stage redirects, so that exactly one instruction per accepted cycle is presented to decode.

---
 rtl/fetch_stage.sv | 73 +++++++
 tb/tb_fetch_stage.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: next-PC select for the external PC register and the
// IF/ID pipeline register with stall, redirect flush and misaligned-target tracking.
module fetch_stage #(
  parameter logic [31:0] NOP_INSTR = 32'h00000013
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] pc,
  output logic [31:0] next_pc,
  output logic        pc_en,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  output logic [31:0] if_id_pc,
  output logic [31:0] if_id_instr,
  output logic        if_id_valid,
  output logic        misalign_err,
  output logic [31:0] fetch_count
);

  logic [31:0] pc_inc;
  logic [31:0] pc_p1;
  logic [31:0] instr_p1;
  logic        vld_p1;
  logic [31:0] count;
  logic        misalign;

  assign imem_addr = pc;
  assign pc_inc    = pc + 32'd4;

  always_comb begin
    next_pc = pc_inc;
    pc_en   = 1'b0;
    if (!reset) begin
      if (redirect_valid) begin
        next_pc = {redirect_target[31:2], 2'b00};
        pc_en   = 1'b1;
      end else begin
        pc_en   = ~stall;
      end
    end
  end

  // Stage p0 -> p1: IF/ID capture. A redirect flushes the wrong-path word even under stall.
  always_ff @(posedge clock) begin
    if (reset) begin
      pc_p1    <= 32'd0;
      instr_p1 <= NOP_INSTR;
      vld_p1   <= 1'b0;
      count    <= 32'd0;
      misalign <= 1'b0;
    end else if (redirect_valid) begin
      instr_p1 <= NOP_INSTR;
      vld_p1   <= 1'b0;
      if (redirect_target[1:0] != 2'b00)
        misalign <= 1'b1;
    end else if (!stall) begin
      pc_p1    <= pc;
      instr_p1 <= imem_rdata;
      vld_p1   <= 1'b1;
      count    <= count + 32'd1;
    end
  end

  assign if_id_pc     = pc_p1;
  assign if_id_instr  = instr_p1;
  assign if_id_valid  = vld_p1;
  assign fetch_count  = count;
  assign misalign_err = misalign;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage with a behavioural PC register and a memory
// that returns 0xA0000000 | address.
module tb_fetch_stage;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] pc;
  logic [31:0] next_pc;
  logic        pc_en;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic [31:0] if_id_pc;
  logic [31:0] if_id_instr;
  logic        if_id_valid;
  logic        misalign_err;
  logic [31:0] fetch_count;

  logic [31:0] pc_reg;
  logic        use_fixed;
  logic [31:0] fixed_pc;

  int total = 0;
  int bad   = 0;

  localparam logic [31:0] NOP = 32'h00000013;

  always #5 clock = ~clock;

  always @(posedge clock) begin
    if (reset) pc_reg <= 32'd0;
    else if (pc_en) pc_reg <= next_pc;
  end

  assign pc         = use_fixed ? fixed_pc : pc_reg;
  assign imem_rdata = 32'hA0000000 | imem_addr;

  fetch_stage #(.NOP_INSTR(NOP)) dut (
    .clock(clock), .reset(reset), .pc(pc), .next_pc(next_pc), .pc_en(pc_en),
    .imem_addr(imem_addr), .imem_rdata(imem_rdata), .stall(stall),
    .redirect_valid(redirect_valid), .redirect_target(redirect_target),
    .if_id_pc(if_id_pc), .if_id_instr(if_id_instr), .if_id_valid(if_id_valid),
    .misalign_err(misalign_err), .fetch_count(fetch_count)
  );

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_target = 32'd0;
    use_fixed = 1'b0; fixed_pc = 32'd0;
    step(); step();
    total++; if (if_id_valid !== 1'b0) begin bad++; $display("FAIL rst_valid got=%0b exp=0", if_id_valid); end
    total++; if (if_id_instr !== NOP) begin bad++; $display("FAIL rst_instr got=%h exp=%h", if_id_instr, NOP); end
    total++; if (if_id_pc !== 32'd0) begin bad++; $display("FAIL rst_pc got=%h exp=0", if_id_pc); end
    total++; if (fetch_count !== 32'd0) begin bad++; $display("FAIL rst_count got=%0d exp=0", fetch_count); end
    total++; if (misalign_err !== 1'b0) begin bad++; $display("FAIL rst_misalign got=%0b exp=0", misalign_err); end
    total++; if (pc_en !== 1'b0) begin bad++; $display("FAIL rst_pc_en got=%0b exp=0", pc_en); end
    total++; if (next_pc !== 32'h4) begin bad++; $display("FAIL rst_next_pc got=%h exp=4", next_pc); end
  endtask

  task automatic test_sequential();
    logic [31:0] exp_pc [3];
    exp_pc[0] = 32'h0; exp_pc[1] = 32'h4; exp_pc[2] = 32'h8;
    reset = 1'b0;
    #1;
    total++; if (pc_en !== 1'b1) begin bad++; $display("FAIL seq_pc_en got=%0b exp=1", pc_en); end
    total++; if (imem_addr !== 32'h0) begin bad++; $display("FAIL seq_imem_addr got=%h exp=0", imem_addr); end
    for (int i = 0; i < 3; i++) begin
      step();
      total++; if (if_id_pc !== exp_pc[i]) begin bad++; $display("FAIL seq_pc[%0d] got=%h exp=%h", i, if_id_pc, exp_pc[i]); end
      total++; if (if_id_instr !== (32'hA0000000 | exp_pc[i])) begin bad++; $display("FAIL seq_instr[%0d] got=%h exp=%h", i, if_id_instr, 32'hA0000000 | exp_pc[i]); end
      total++; if (if_id_valid !== 1'b1) begin bad++; $display("FAIL seq_valid[%0d] got=%0b exp=1", i, if_id_valid); end
      total++; if (fetch_count !== 32'(i + 1)) begin bad++; $display("FAIL seq_count[%0d] got=%0d exp=%0d", i, fetch_count, i + 1); end
    end
  endtask

  task automatic test_stall();
    stall = 1'b1;
    #1;
    total++; if (pc_en !== 1'b0) begin bad++; $display("FAIL stall_pc_en got=%0b exp=0", pc_en); end
    for (int i = 0; i < 3; i++) begin
      step();
      total++; if (if_id_pc !== 32'h8) begin bad++; $display("FAIL stall_hold_pc[%0d] got=%h exp=8", i, if_id_pc); end
      total++; if (fetch_count !== 32'd3) begin bad++; $display("FAIL stall_count[%0d] got=%0d exp=3", i, fetch_count); end
      total++; if (pc !== 32'hC) begin bad++; $display("FAIL stall_pc_frozen[%0d] got=%h exp=c", i, pc); end
    end
    stall = 1'b0;
    step();
    total++; if (if_id_pc !== 32'hC) begin bad++; $display("FAIL stall_rel1 got=%h exp=c", if_id_pc); end
    total++; if (fetch_count !== 32'd4) begin bad++; $display("FAIL stall_rel1_count got=%0d exp=4", fetch_count); end
    step();
    total++; if (if_id_pc !== 32'h10) begin bad++; $display("FAIL stall_rel2 got=%h exp=10", if_id_pc); end
    total++; if (fetch_count !== 32'd5) begin bad++; $display("FAIL stall_rel2_count got=%0d exp=5", fetch_count); end
  endtask

  task automatic test_redirect();
    redirect_valid = 1'b1; redirect_target = 32'h100;
    #1;
    total++; if (next_pc !== 32'h100) begin bad++; $display("FAIL redir_next_pc got=%h exp=100", next_pc); end
    total++; if (pc_en !== 1'b1) begin bad++; $display("FAIL redir_pc_en got=%0b exp=1", pc_en); end
    step();
    redirect_valid = 1'b0;
    total++; if (pc !== 32'h100) begin bad++; $display("FAIL redir_pc got=%h exp=100", pc); end
    total++; if (if_id_valid !== 1'b0) begin bad++; $display("FAIL redir_bubble_valid got=%0b exp=0", if_id_valid); end
    total++; if (if_id_instr !== NOP) begin bad++; $display("FAIL redir_bubble_instr got=%h exp=%h", if_id_instr, NOP); end
    total++; if (if_id_pc !== 32'h10) begin bad++; $display("FAIL redir_if_id_pc_kept got=%h exp=10", if_id_pc); end
    total++; if (fetch_count !== 32'd5) begin bad++; $display("FAIL redir_count got=%0d exp=5", fetch_count); end
    step();
    total++; if (if_id_pc !== 32'h100) begin bad++; $display("FAIL redir_target_pc got=%h exp=100", if_id_pc); end
    total++; if (if_id_instr !== 32'hA0000100) begin bad++; $display("FAIL redir_target_instr got=%h exp=a0000100", if_id_instr); end
    total++; if (fetch_count !== 32'd6) begin bad++; $display("FAIL redir_target_count got=%0d exp=6", fetch_count); end
  endtask

  task automatic test_redirect_stall_misalign();
    stall = 1'b1; redirect_valid = 1'b1; redirect_target = 32'h202;
    #1;
    total++; if (next_pc !== 32'h200) begin bad++; $display("FAIL rs_next_pc got=%h exp=200", next_pc); end
    total++; if (pc_en !== 1'b1) begin bad++; $display("FAIL rs_pc_en got=%0b exp=1", pc_en); end
    step();
    redirect_valid = 1'b0;
    total++; if (pc !== 32'h200) begin bad++; $display("FAIL rs_pc got=%h exp=200", pc); end
    total++; if (if_id_valid !== 1'b0) begin bad++; $display("FAIL rs_bubble got=%0b exp=0", if_id_valid); end
    total++; if (misalign_err !== 1'b1) begin bad++; $display("FAIL rs_misalign got=%0b exp=1", misalign_err); end
    step();
    total++; if (pc !== 32'h200) begin bad++; $display("FAIL rs_stall_pc got=%h exp=200", pc); end
    total++; if (if_id_valid !== 1'b0) begin bad++; $display("FAIL rs_stall_bubble got=%0b exp=0", if_id_valid); end
    total++; if (fetch_count !== 32'd6) begin bad++; $display("FAIL rs_stall_count got=%0d exp=6", fetch_count); end
    stall = 1'b0;
    step();
    total++; if (if_id_pc !== 32'h200) begin bad++; $display("FAIL rs_target_pc got=%h exp=200", if_id_pc); end
    total++; if (fetch_count !== 32'd7) begin bad++; $display("FAIL rs_target_count got=%0d exp=7", fetch_count); end
    total++; if (misalign_err !== 1'b1) begin bad++; $display("FAIL rs_misalign_sticky got=%0b exp=1", misalign_err); end
  endtask

  task automatic test_back_to_back();
    redirect_valid = 1'b1; redirect_target = 32'h300;
    step();
    total++; if (pc !== 32'h300) begin bad++; $display("FAIL b2b_pc1 got=%h exp=300", pc); end
    total++; if (if_id_valid !== 1'b0) begin bad++; $display("FAIL b2b_bubble1 got=%0b exp=0", if_id_valid); end
    redirect_target = 32'h400;
    step();
    redirect_valid = 1'b0;
    total++; if (pc !== 32'h400) begin bad++; $display("FAIL b2b_pc2 got=%h exp=400", pc); end
    total++; if (if_id_valid !== 1'b0) begin bad++; $display("FAIL b2b_bubble2 got=%0b exp=0", if_id_valid); end
    total++; if (fetch_count !== 32'd7) begin bad++; $display("FAIL b2b_count got=%0d exp=7", fetch_count); end
    step();
    total++; if (if_id_pc !== 32'h400) begin bad++; $display("FAIL b2b_target got=%h exp=400", if_id_pc); end
    total++; if (if_id_valid !== 1'b1) begin bad++; $display("FAIL b2b_valid got=%0b exp=1", if_id_valid); end
    total++; if (fetch_count !== 32'd8) begin bad++; $display("FAIL b2b_count2 got=%0d exp=8", fetch_count); end
  endtask

  task automatic test_wrap();
    use_fixed = 1'b1; fixed_pc = 32'hFFFFFFFC;
    #1;
    total++; if (next_pc !== 32'h0) begin bad++; $display("FAIL wrap_next_pc got=%h exp=0", next_pc); end
    total++; if (imem_addr !== 32'hFFFFFFFC) begin bad++; $display("FAIL wrap_imem_addr got=%h exp=fffffffc", imem_addr); end
    total++; if (pc_en !== 1'b1) begin bad++; $display("FAIL wrap_pc_en got=%0b exp=1", pc_en); end
    use_fixed = 1'b0;
    #1;
  endtask

  task automatic test_reset_mid();
    stall = 1'b1;
    step();
    total++; if (fetch_count !== 32'd8) begin bad++; $display("FAIL rm_pre_count got=%0d exp=8", fetch_count); end
    reset = 1'b1; redirect_valid = 1'b1; redirect_target = 32'h502;
    #1;
    total++; if (pc_en !== 1'b0) begin bad++; $display("FAIL rm_pc_en_comb got=%0b exp=0", pc_en); end
    step();
    total++; if (fetch_count !== 32'd0) begin bad++; $display("FAIL rm_count got=%0d exp=0", fetch_count); end
    total++; if (if_id_valid !== 1'b0) begin bad++; $display("FAIL rm_valid got=%0b exp=0", if_id_valid); end
    total++; if (misalign_err !== 1'b0) begin bad++; $display("FAIL rm_misalign got=%0b exp=0", misalign_err); end
    total++; if (if_id_pc !== 32'd0) begin bad++; $display("FAIL rm_if_id_pc got=%h exp=0", if_id_pc); end
    total++; if (if_id_instr !== NOP) begin bad++; $display("FAIL rm_instr got=%h exp=%h", if_id_instr, NOP); end
    total++; if (pc_en !== 1'b0) begin bad++; $display("FAIL rm_pc_en got=%0b exp=0", pc_en); end
    reset = 1'b0; stall = 1'b0; redirect_valid = 1'b0;
    step();
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_stall();
    test_redirect();
    test_redirect_stall_misalign();
    test_back_to_back();
    test_wrap();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
